// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer in front of a combinational ROM.
// Owns the fetch PC, buffers {pc, instr} pairs in a 2-entry FIFO toward
// decode, and handles redirects, halts and out-of-window/misaligned faults.
// Optional macro FETCH_CNT_EN enables the pushed-instruction counter.
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_AW    = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic [IM_AW-1:0]  iaddr,
  input  logic [31:0]       idata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              fault,
  output logic [31:0]       fault_pc,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  // Size of the fetchable window in bytes
  localparam logic [31:0] WIN_BYTES = 32'd4 << IM_AW;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_fault_pc;
  logic [1:0]  r_count;
  logic        r_head;
  logic        r_tail;
  logic [31:0] r_q_pc    [2];
  logic [31:0] r_q_instr [2];

  logic [31:0] w_off;
  logic        w_in_window;
  logic        w_push;
  logic        w_pop;
  logic        w_set_fault;

  // Below-base PCs wrap to large offsets and fall outside the window
  assign w_off       = r_fetch_pc - PC_RESET;
  assign w_in_window = (r_fetch_pc[1:0] == 2'b00) && (w_off < WIN_BYTES);
  assign iaddr       = w_off[IM_AW+1:2];

  assign out_valid = (r_count != 2'd0);
  assign out_pc    = out_valid ? r_q_pc[r_head]    : 32'h0;
  assign out_instr = out_valid ? r_q_instr[r_head] : 32'h0;
  assign fault     = (r_state == FAULT);
  assign fault_pc  = r_fault_pc;

  // Handshake decode and next-state logic; redirect overrides everything
  always_comb begin
    w_pop       = out_valid && out_ready && !redirect_valid;
    // A full queue still accepts a push when the head leaves this cycle
    w_push      = (r_state == RUN) && !halt_req && !redirect_valid &&
                  w_in_window && ((r_count != 2'd2) || w_pop);
    w_state_nxt = r_state;
    w_set_fault = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = halt_req ? HALT : RUN;
    end else begin
      case (r_state)
        RUN: begin
          if (halt_req) begin
            w_state_nxt = HALT;
          end else if (!w_in_window) begin
            w_state_nxt = FAULT;
            w_set_fault = 1'b1;
          end
        end
        HALT: begin
          if (!halt_req) w_state_nxt = RUN;
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // Control state: FSM, fetch PC, queue pointers/count, fault PC
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= RUN;
      r_fetch_pc <= PC_RESET;
      r_fault_pc <= 32'h0;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_fault) r_fault_pc <= r_fetch_pc;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_count    <= 2'd0;
        r_head     <= 1'b0;
        r_tail     <= 1'b0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_tail     <= ~r_tail;
        end
        if (w_pop) r_head <= ~r_head;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Queue storage; contents are only observed through the count-gated outputs
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]    <= r_fetch_pc;
      r_q_instr[r_tail] <= idata;
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] r_fetch_count;

  // Pushed-instruction counter; only reset clears it, redirects do not
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_count <= 32'h0;
    end else if (w_push) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`else
  assign fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a behavioural ROM.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  iaddr;
  logic [31:0] idata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt_req = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  fetch_ctrl #(.PC_RESET(32'h0000_3000), .IM_AW(10)) dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fault(fault),
    .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Words 0..3 are 0x11..0x44; all others carry their own address
  function automatic logic [31:0] rom_word(input logic [9:0] a);
    if (a < 10'd4) return (32'(a) + 32'd1) * 32'h11;
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  assign idata = rom_word(iaddr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    // 1: reset state and streaming with ready high
    out_ready = 1'b1;
    reset = 1'b0;
    step(2);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_fault_pc", fault_pc, 32'h0);
    check("rst_fcount", fetch_count, 32'h0);
    check("rst_iaddr", 32'(iaddr), 32'd0);
    reset = 1'b1;
    step();
    check("t1_pc0", out_pc, 32'h3000);
    check("t1_in0", out_instr, 32'h11);
    check("t1_iaddr1", 32'(iaddr), 32'd1);
    step();
    check("t1_pc1", out_pc, 32'h3004);
    check("t1_in1", out_instr, 32'h22);
    check("t1_iaddr2", 32'(iaddr), 32'd2);
    step();
    check("t1_pc2", out_pc, 32'h3008);
    check("t1_in2", out_instr, 32'h33);

    // 2: backpressure fills the queue, then drains in order
    out_ready = 1'b0;
    do_reset();
    step(5);
    check("t2_valid", 32'(out_valid), 32'd1);
    check("t2_hold_pc", out_pc, 32'h3000);
    check("t2_hold_in", out_instr, 32'h11);
    check("t2_fpc", 32'(iaddr), 32'd2);
    out_ready = 1'b1;
    step();
    check("t2_drain1", out_pc, 32'h3004);
    check("t2_drain1_in", out_instr, 32'h22);
    step();
    check("t2_drain2", out_pc, 32'h3008);

    // 3: redirect while full
    out_ready = 1'b0;
    do_reset();
    step(2);
    check("t3_full_pc", out_pc, 32'h3000);
    out_ready = 1'b1;
    redirect(32'h3100);
    check("t3_flush", 32'(out_valid), 32'd0);
    check("t3_iaddr", 32'(iaddr), 32'h40);
    step();
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_pc", out_pc, 32'h3100);
    check("t3_instr", out_instr, 32'hC0DE_0040);

    // 4: last window word, then fault; misaligned redirect faults too
    redirect(32'h3FFC);
    check("t4_flush", 32'(out_valid), 32'd0);
    step();
    check("t4_last_pc", out_pc, 32'h3FFC);
    check("t4_last_in", out_instr, 32'hC0DE_03FF);
    check("t4_nofault", 32'(fault), 32'd0);
    step();
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_fault_pc", fault_pc, 32'h4000);
    check("t4_empty", 32'(out_valid), 32'd0);
    step(2);
    check("t4_stay_fault", 32'(fault), 32'd1);
    check("t4_no_push", 32'(out_valid), 32'd0);
    redirect(32'h3002);
    check("t4_cleared", 32'(fault), 32'd0);
    step();
    check("t4_mis_fault", 32'(fault), 32'd1);
    check("t4_mis_pc", fault_pc, 32'h3002);
    redirect(32'h2FFC);
    check("t4_below_clr", 32'(fault), 32'd0);
    step();
    check("t4_below_fault", 32'(fault), 32'd1);
    check("t4_below_pc", fault_pc, 32'h2FFC);

    // 5: halt mid-stream, resume without gap or duplicate
    redirect(32'h3000);
    check("t5_flush", 32'(out_valid), 32'd0);
    step();
    check("t5_pc0", out_pc, 32'h3000);
    step();
    check("t5_pc1", out_pc, 32'h3004);
    halt_req = 1'b1;
    step();
    check("t5_drained", 32'(out_valid), 32'd0);
    check("t5_held_fpc", 32'(iaddr), 32'd2);
    step(2);
    check("t5_halt_nopush", 32'(out_valid), 32'd0);
    halt_req = 1'b0;
    step();
    check("t5_resume0", 32'(out_valid), 32'd0);
    step();
    check("t5_pc2", out_pc, 32'h3008);
    check("t5_in2", out_instr, 32'h33);
    step();
    check("t5_pc3", out_pc, 32'h300C);
    check("t5_in3", out_instr, 32'h44);

    // 6: push counter across a redirect
    out_ready = 1'b1;
    do_reset();
    check("t6_cnt0", fetch_count, 32'd0);
    step(10);
    check("t6_cnt10", fetch_count, CNT_EN ? 32'd10 : 32'd0);
    redirect(32'h3000);
    check("t6_cnt_redir", fetch_count, CNT_EN ? 32'd10 : 32'd0);
    step(3);
    check("t6_cnt13", fetch_count, CNT_EN ? 32'd13 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
